// File: rtl/config_reg.sv
// config_reg: addressable config register slice on the config chain.
// Writes/reads on address match, forwards all other packets unchanged.
module config_reg #(
  parameter int ADDR_SIZE = 4,
  parameter int PAYLOAD_SIZE = 8,
  parameter logic [ADDR_SIZE-1:0] REG_ADDR = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic recv_val,
  output logic recv_rdy,
  input  logic [ADDR_SIZE+PAYLOAD_SIZE:0] recv_msg,
  output logic send_val,
  input  logic send_rdy,
  output logic [ADDR_SIZE+PAYLOAD_SIZE:0] send_msg,
  output logic [PAYLOAD_SIZE-1:0] config_out
);

  localparam int W = ADDR_SIZE + PAYLOAD_SIZE + 1;

  logic [ADDR_SIZE-1:0] addr;
  logic wr;
  logic [PAYLOAD_SIZE-1:0] data;
  logic accept;
  logic hit;

  logic [PAYLOAD_SIZE-1:0] cfg_q;
  logic [PAYLOAD_SIZE-1:0] cfg_d;
  logic [W-1:0] msg_d;
  logic val_d;

  assign addr = recv_msg[W-1:PAYLOAD_SIZE+1];
  assign wr = recv_msg[PAYLOAD_SIZE];
  assign data = recv_msg[PAYLOAD_SIZE-1:0];

  // Single-entry buffer may refill in the cycle it drains.
  assign recv_rdy = !send_val || send_rdy;
  assign accept = recv_val && recv_rdy;
  assign hit = (addr == REG_ADDR);

  always_comb begin
    cfg_d = cfg_q;
    msg_d = send_msg;
    val_d = send_val;
    unique case (1'b1)
      !accept: begin
        val_d = send_val && !send_rdy;
      end
      accept && hit && wr: begin
        cfg_d = data;
        msg_d = recv_msg;
        val_d = 1'b1;
      end
      accept && hit && !wr: begin
        msg_d = {addr, 1'b0, cfg_q};
        val_d = 1'b1;
      end
      accept && !hit: begin
        msg_d = recv_msg;
        val_d = 1'b1;
      end
      default: begin
        val_d = send_val;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q <= '0;
      send_msg <= '0;
      send_val <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      send_msg <= msg_d;
      send_val <= val_d;
    end
  end

  assign config_out = cfg_q;

endmodule

// File: tb/tb_config_reg.sv
// tb_config_reg: directed stimulus, behavioural model compared each cycle,
// plus literal expectations at key points.
module tb_config_reg;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic recv_val = 1'b0;
  logic recv_rdy;
  logic [12:0] recv_msg = '0;
  logic send_val;
  logic send_rdy = 1'b1;
  logic [12:0] send_msg;
  logic [7:0] config_out;

  int n_pass = 0;
  int n_tot = 0;
  bit armed = 1'b0;

  config_reg #(
    .ADDR_SIZE(4),
    .PAYLOAD_SIZE(8),
    .REG_ADDR(4'd0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .recv_val(recv_val),
    .recv_rdy(recv_rdy),
    .recv_msg(recv_msg),
    .send_val(send_val),
    .send_rdy(send_rdy),
    .send_msg(send_msg),
    .config_out(config_out)
  );

  always #5 clk = ~clk;

  // Model: stored value plus a queue holding at most one outgoing packet.
  int m_cfg = 0;
  int m_msg = 0;
  int m_buf[$];

  always @(posedge clk) begin
    int a, w, d, reply;
    bit rdy;
    if (reset) begin
      m_cfg = 0;
      m_msg = 0;
      m_buf.delete();
    end else begin
      rdy = (m_buf.size() == 0) || send_rdy;
      if (send_rdy && m_buf.size() > 0) void'(m_buf.pop_front());
      if (recv_val && rdy) begin
        a = int'(recv_msg) / 512;
        w = (int'(recv_msg) / 256) % 2;
        d = int'(recv_msg) % 256;
        if (a == 0 && w == 1) begin
          reply = int'(recv_msg);
          m_cfg = d;
        end else if (a == 0) begin
          reply = m_cfg;
        end else begin
          reply = int'(recv_msg);
        end
        m_buf.push_back(reply);
        m_msg = reply;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check("m_val", 16'(send_val), 16'(m_buf.size() != 0));
      check("m_msg", 16'(send_msg), 16'(m_msg));
      check("m_cfg", 16'(config_out), 16'(m_cfg));
      check("m_rdy", 16'(recv_rdy),
            16'((m_buf.size() == 0) || send_rdy));
    end
  end

  task automatic set(input logic rst, input logic rv,
                     input logic [12:0] msg, input logic sr);
    #1;
    reset = rst;
    recv_val = rv;
    recv_msg = msg;
    send_rdy = sr;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    set(1, 1, 13'h1FF, 1);
    nxt();
    armed = 1'b1;
    check("rst_msg", 16'(send_msg), 16'h0000);
    check("rst_cfg", 16'(config_out), 16'h0000);
    check("rst_val", 16'(send_val), 16'h0000);
    check("rst_rdy", 16'(recv_rdy), 16'h0001);

    set(0, 1, 13'h155, 1);
    nxt();
    check("wr_msg", 16'(send_msg), 16'h0155);
    check("wr_cfg", 16'(config_out), 16'h0055);

    set(0, 1, 13'h055, 1);
    nxt();
    check("rd_msg", 16'(send_msg), 16'h0055);

    set(0, 1, 13'h000, 1);
    nxt();
    check("rd0_msg", 16'(send_msg), 16'h0055);
    check("rd0_cfg", 16'(config_out), 16'h0055);

    set(0, 1, 13'hB55, 1);
    nxt();
    check("fwd_wr", 16'(send_msg), 16'h0B55);
    check("fwd_cfg", 16'(config_out), 16'h0055);

    set(0, 1, 13'hA55, 1);
    nxt();
    check("fwd_rd", 16'(send_msg), 16'h0A55);

    set(0, 1, 13'h1AA, 0);
    for (int i = 0; i < 3; i++) begin
      nxt();
      check("bp_rdy", 16'(recv_rdy), 16'h0000);
      check("bp_msg", 16'(send_msg), 16'h0A55);
      check("bp_cfg", 16'(config_out), 16'h0055);
    end

    set(0, 1, 13'h1AA, 1);
    nxt();
    check("bp_acc", 16'(send_msg), 16'h01AA);
    check("aa_cfg", 16'(config_out), 16'h00AA);

    set(0, 1, 13'h000, 1);
    nxt();
    check("rd_aa", 16'(send_msg), 16'h00AA);

    set(0, 0, 13'h000, 1);
    nxt();
    check("idle_val", 16'(send_val), 16'h0000);
    check("idle_msg", 16'(send_msg), 16'h00AA);

    set(0, 1, 13'h3FF, 0);
    nxt();
    check("empty_acc", 16'(send_msg), 16'h03FF);
    check("empty_val", 16'(send_val), 16'h0001);

    set(1, 1, 13'h1CC, 1);
    nxt();
    check("mid_rst_cfg", 16'(config_out), 16'h0000);
    check("mid_rst_val", 16'(send_val), 16'h0000);

    set(0, 1, 13'h133, 1);
    nxt();
    check("dup1_msg", 16'(send_msg), 16'h0133);
    nxt();
    check("dup2_msg", 16'(send_msg), 16'h0133);
    check("dup2_val", 16'(send_val), 16'h0001);
    check("dup2_cfg", 16'(config_out), 16'h0033);

    set(0, 1, 13'h000, 1);
    nxt();
    check("rdw_msg", 16'(send_msg), 16'h0033);

    set(0, 0, 13'h000, 1);
    nxt();
    nxt();
    armed = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
